// File: rtl/param_sp_ram_pkg.sv
// ============================================================================
// Module  : param_sp_ram_pkg
// Brief   : Shared constants and types for the parametrised single-port RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package param_sp_ram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

endpackage

`default_nettype wire

// File: rtl/param_sp_ram_clear_ctrl.sv
// ============================================================================
// Module  : param_sp_ram_clear_ctrl
// Brief   : Post-reset clear sequencer; walks every word once, then flags ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module param_sp_ram_clear_ctrl
  import param_sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam ram_state_t            RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  // ready trails the state by one edge so the last clear write has landed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = (state_q == ST_READY);
    if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign clear_we   = (state_q == ST_CLEAR);
  assign clear_addr = cnt_q;
  assign ready      = ready_q;

endmodule

`default_nettype wire

// File: rtl/param_sp_ram.sv
// ============================================================================
// Module  : param_sp_ram
// Brief   : Parametrised single-port RAM with byte lanes, RDW modes and clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module param_sp_ram
  import param_sp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    DEPTH       = 2**ADDR_WIDTH,
  parameter int                    RDW_MODE    = 0,
  parameter int                    OUT_REG     = 0,
  parameter int                    INIT_CLEAR  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    ready
);

  localparam int                  LANES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("param_sp_ram: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_chk_depth
    $error("param_sp_ram: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (RDW_MODE > 2) begin : g_chk_rdw
    $error("param_sp_ram: RDW_MODE must be 0, 1 or 2");
  end

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  param_sp_ram_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .ready      (ready)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  in_range;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  rv_q, rv_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_mask[8*i +: 8] = {8{be[i]}};
  end

  assign in_range    = ({1'b0, addr} < DEPTH_W);
  assign old_word    = in_range ? mem_q[addr] : '0;
  assign merged_word = (old_word & ~lane_mask) | (data & lane_mask);

  // Clear writes own the port until ready; user writes are gated by ready.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_word = merged_word;
    if (clear_we) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr;
      wr_word = CLEAR_VALUE;
    end else if (ready && we && in_range && (|be)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  always_comb begin
    rd_d = rd_q;
    rv_d = 1'b0;
    if (ready && re && !(we && RDW_MODE == RDW_NO_CHANGE)) begin
      rv_d = 1'b1;
      if (!in_range) begin
        rd_d = '0;
      end else if (we && RDW_MODE == RDW_WRITE_FIRST) begin
        rd_d = merged_word;
      end else begin
        rd_d = old_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      rv_q <= rv_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q2_q, q2_d;
    logic                  v2_q, v2_d;

    always_comb begin
      q2_d = rv_q ? rd_q : q2_q;
      v2_d = rv_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        q2_q <= q2_d;
        v2_q <= v2_d;
      end
    end

    assign q       = q2_q;
    assign q_valid = v2_q;
  end else begin : g_no_out_reg
    assign q       = rd_q;
    assign q_valid = rv_q;
  end

endmodule

`default_nettype wire
